alu_seq: RTL and testbench

Parametrised, registered successor to the datapath ALU. Takes W-bit operands and a 3-bit opcode on a start strobe, returns a registered result with a start/busy/done handshake, and maintains a Z/N/V status register. Adds an optional iterative shift-add multiplier. Sits between the operand muxes and the C register / status register of the datapath, and is sequenced by the controller FSM.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 149 ++++++++++++++
 tb/tb_alu_seq.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand/result bundle between the datapath controller and alu_seq.
// The master drives start/ALUop/Ain/Bin; the slave (the ALU) drives result, status and handshake.
interface alu_seq_if #(
   parameter int W = 16
);
   logic         start;
   logic [2:0]   ALUop;
   logic [W-1:0] Ain;
   logic [W-1:0] Bin;
   logic [W-1:0] out;
   logic         Z;
   logic         N;
   logic         V;
   logic         busy;
   logic         done;
   logic         illegal;

   modport master (
      output start, ALUop, Ain, Bin,
      input  out, Z, N, V, busy, done, illegal
   );

   modport slave (
      input  start, ALUop, Ain, Bin,
      output out, Z, N, V, busy, done, illegal
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered W-bit ALU with Z/N/V status and a start/busy/done handshake.
// Define ALU_MUL_EN to add the iterative shift-add multiplier (opcode 100, RUN state).
module alu_seq #(
   parameter int W = 16
) (
   input  logic     clk,
   input  logic     reset,
   alu_seq_if.slave bus,
   output logic     dbg_state
);
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
`ifdef ALU_MUL_EN
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam int         CW     = $clog2(W);
   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
`else
   typedef enum logic {S_IDLE = 1'b0} state_t;
`endif

   state_t       state_q, state_d;
   logic [W-1:0] out_q, out_d;
   logic         z_q, z_d, n_q, n_d, v_q, v_d;
   logic         done_q, done_d, illegal_q, illegal_d;
   logic         upd;
   logic [W-1:0] add_res, sub_res;
   logic         add_v, sub_v;
`ifdef ALU_MUL_EN
   logic [2*W-1:0] a_q, a_d, acc_q, acc_d, acc_nxt;
   logic [W-1:0]   b_q, b_d;
   logic [CW-1:0]  cnt_q, cnt_d;
`endif

   always_comb begin
      add_res = bus.Ain + bus.Bin;
      sub_res = bus.Ain - bus.Bin;
      add_v   = (bus.Ain[W-1] == bus.Bin[W-1]) && (add_res[W-1] != bus.Ain[W-1]);
      sub_v   = (bus.Ain[W-1] != bus.Bin[W-1]) && (sub_res[W-1] != bus.Ain[W-1]);
   end

   // Handshake: start is honoured only while busy=0 (any state other than RUN);
   // done pulses for one cycle when out/Z/N/V/illegal are valid; busy and done never overlap.
   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      z_d       = z_q;
      n_d       = n_q;
      v_d       = v_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      upd       = 1'b0;
`ifdef ALU_MUL_EN
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      acc_nxt = acc_q + (b_q[0] ? a_q : '0);
`endif
      if (state_q == S_IDLE) begin
         if (bus.start) begin
            done_d = 1'b1;
            case (bus.ALUop)
               OP_ADD: begin out_d = add_res;             v_d = add_v; upd = 1'b1; end
               OP_SUB: begin out_d = sub_res;             v_d = sub_v; upd = 1'b1; end
               OP_AND: begin out_d = bus.Ain & bus.Bin;   v_d = 1'b0;  upd = 1'b1; end
               OP_NOT: begin out_d = ~bus.Bin;            v_d = 1'b0;  upd = 1'b1; end
`ifdef ALU_MUL_EN
               OP_MUL: begin
                  done_d  = 1'b0;
                  a_d     = {{W{1'b0}}, bus.Ain};
                  b_d     = bus.Bin;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end
`endif
               default: illegal_d = 1'b1;
            endcase
         end
      end
`ifdef ALU_MUL_EN
      else begin
         acc_d = acc_nxt;
         a_d   = a_q << 1;
         b_d   = b_q >> 1;
         cnt_d = cnt_q + CW'(1);
         // Last iteration: the result includes this cycle's partial-product add.
         if (cnt_q == CW'(W - 1)) begin
            out_d   = acc_nxt[W-1:0];
            v_d     = |acc_nxt[2*W-1:W];
            upd     = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      end
`endif
      if (upd) begin
         z_d = (out_d == '0);
         n_d = out_d[W-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         out_q     <= '0;
         z_q       <= 1'b0;
         n_q       <= 1'b0;
         v_q       <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         z_q       <= z_d;
         n_q       <= n_d;
         v_q       <= v_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign bus.out     = out_q;
   assign bus.Z       = z_q;
   assign bus.N       = n_q;
   assign bus.V       = v_q;
   assign bus.done    = done_q;
   assign bus.illegal = illegal_q;
   assign dbg_state   = state_q;
`ifdef ALU_MUL_EN
   assign bus.busy    = (state_q == S_RUN);
`else
   assign bus.busy    = 1'b0;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=16); multiplier scenarios run when ALU_MUL_EN is defined,
// otherwise opcode 100 is exercised as a reserved opcode.
module tb_alu_seq;
   localparam int W  = 16;
   localparam int EW = W + 4;

   logic clk;
   logic reset;
   logic dbg_state;
   int   checks;
   int   errors;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] cur_exp;

   alu_seq_if #(.W(W)) bus ();

   alu_seq #(.W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // Reference model; expected vector packing is {illegal, V, N, Z, out}.
   function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0]   r;
      logic           v;
      longint         s;
      longint         smax;
      logic [2*W-1:0] p;
      smax = (longint'(1) << (W - 1)) - 1;
      v    = 1'b0;
      r    = '0;
      case (op)
         3'b000: begin r = a + b; s = longint'($signed(a)) + longint'($signed(b)); v = (s > smax) || (s < -smax - 1); end
         3'b001: begin r = a - b; s = longint'($signed(a)) - longint'($signed(b)); v = (s > smax) || (s < -smax - 1); end
         3'b010: r = a & b;
         3'b011: r = ~b;
`ifdef ALU_MUL_EN
         3'b100: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; v = |p[2*W-1:W]; end
`endif
         default: return {1'b1, cur_exp[EW-2:0]};
      endcase
      return {1'b0, v, r[W-1], (r == '0), r};
   endfunction

   // Driver: presents one request for one edge and records its expected result.
   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [EW-1:0] e;
      e = model(op, a, b);
      if (!e[EW-1]) cur_exp = e;
      exp_q.push_back(e);
      bus.start = 1'b1;
      bus.ALUop = op;
      bus.Ain   = a;
      bus.Bin   = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.Ain   = W'($urandom);
      bus.Bin   = W'($urandom);
      bus.ALUop = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_done(input int limit, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.done !== 1'b1 && n < limit);
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, bus.done, n);
      end
   endtask

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge clk) begin
      logic [EW-1:0] got;
      logic [EW-1:0] e;
      if (reset === 1'b0 && bus.done === 1'b1) begin
         got = {bus.illegal, bus.V, bus.N, bus.Z, bus.out};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_done got=%h required no done", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e || bus.busy !== 1'b0) begin
               errors++;
               $display("FAIL sb_result got=%h busy=%b required=%h busy=0", got, bus.busy, e);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.out, bus.Z, bus.N, bus.V, bus.busy, bus.done, bus.illegal} !== {W'(0), 6'b0}) begin
         errors++;
         $display("FAIL reset_state got out=%h ZNV=%b%b%b busy=%b done=%b ill=%b required all 0",
                  bus.out, bus.Z, bus.N, bus.V, bus.busy, bus.done, bus.illegal);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      cur_exp = '0;
   endtask

   task automatic test_single_ops();
      logic [2:0]   ops [6] = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b011, 3'b010};
      logic [W-1:0] as  [6] = '{16'hF0CF, 16'hF0CF, 16'h7FFF, 16'hF0CF, 16'h1234, 16'h0000};
      logic [W-1:0] bs  [6] = '{16'hB965, 16'hB965, 16'h0001, 16'hF0CF, 16'hFFFF, 16'h0000};
      logic [W-1:0] rs  [6] = '{16'hAA34, 16'h376A, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
      logic [2:0]   fs  [6] = '{3'b010, 3'b000, 3'b011, 3'b100, 3'b100, 3'b100};
      for (int i = 0; i < 6; i++) begin
         send(ops[i], as[i], bs[i]);
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b1 || bus.out !== rs[i] || {bus.Z, bus.N, bus.V} !== fs[i] || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_op%0d got done=%b out=%h ZNV=%b busy=%b required done=1 out=%h ZNV=%b busy=0",
                     i, bus.done, bus.out, {bus.Z, bus.N, bus.V}, bus.busy, rs[i], fs[i]);
         end
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse%0d got done=%b required 0", i, bus.done);
         end
      end
   endtask

   task automatic test_back_to_back_random();
      logic [2:0] op;
      for (int i = 0; i < 30; i++) begin
         op = (i % 7 == 6) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 3));
         send(op, W'($urandom), W'($urandom));
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_hold_and_illegal();
      logic [2:0] rsv [4] = '{3'b111, 3'b101, 3'b110, 3'b100};
      int         nr;
`ifdef ALU_MUL_EN
      nr = 3;
`else
      nr = 4;
`endif
      send(3'b000, 16'h1000, 16'h0234);
      @(negedge clk);
      repeat (3) @(negedge clk);
      checks++;
      if (bus.out !== 16'h1234 || bus.done !== 1'b0 || {bus.Z, bus.N, bus.V} !== 3'b000) begin
         errors++;
         $display("FAIL hold got out=%h done=%b ZNV=%b required out=1234 done=0 ZNV=000",
                  bus.out, bus.done, {bus.Z, bus.N, bus.V});
      end
      for (int i = 0; i < nr; i++) begin
         send(rsv[i], W'($urandom), W'($urandom));
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b1 || bus.illegal !== 1'b1 || bus.out !== 16'h1234 ||
             {bus.Z, bus.N, bus.V} !== 3'b000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_op%0d got done=%b ill=%b out=%h ZNV=%b busy=%b required 1 1 1234 000 0",
                     rsv[i], bus.done, bus.illegal, bus.out, {bus.Z, bus.N, bus.V}, bus.busy);
         end
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.illegal !== 1'b0 || bus.busy !== 1'b0 || bus.out !== 16'h1234) begin
            errors++;
            $display("FAIL illegal_pulse%0d got done=%b ill=%b busy=%b out=%h required 0 0 0 1234",
                     rsv[i], bus.done, bus.illegal, bus.busy, bus.out);
         end
      end
   endtask

`ifdef ALU_MUL_EN
   task automatic test_mul();
      int bc;
      send(3'b100, 16'h0123, 16'h0010);
      bc = 0;
      repeat (W) begin
         @(negedge clk);
         if (bus.busy === 1'b1 && bus.done === 1'b0 && dbg_state === 1'b1) bc++;
      end
      checks++;
      if (bc !== W) begin
         errors++;
         $display("FAIL mul_busy_cycles got=%0d required=%0d", bc, W);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out !== 16'h1230 || {bus.Z, bus.N, bus.V} !== 3'b000) begin
         errors++;
         $display("FAIL mul_result got done=%b busy=%b out=%h ZNV=%b required 1 0 1230 000",
                  bus.done, bus.busy, bus.out, {bus.Z, bus.N, bus.V});
      end
      send(3'b100, 16'h0100, 16'h0100);
      wait_done(W + 2, "mul_overflow");
      checks++;
      if (bus.out !== 16'h0000 || {bus.Z, bus.N, bus.V} !== 3'b101) begin
         errors++;
         $display("FAIL mul_overflow got out=%h ZNV=%b required 0000 101", bus.out, {bus.Z, bus.N, bus.V});
      end
   endtask

   task automatic test_mul_ignore_and_back_to_back();
      send(3'b100, 16'h00FF, 16'h0003);
      repeat (4) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.ALUop = 3'b000;
      bus.Ain   = 16'h4444;
      bus.Bin   = 16'h1111;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(W + 2, "mul_ignore");
      checks++;
      if (bus.out !== 16'h02FD || {bus.Z, bus.N, bus.V} !== 3'b000) begin
         errors++;
         $display("FAIL mul_ignore got out=%h ZNV=%b required 02fd 000", bus.out, {bus.Z, bus.N, bus.V});
      end
      send(3'b000, 16'h0001, 16'h0002);
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.out !== 16'h0003) begin
         errors++;
         $display("FAIL back_to_back got done=%b out=%h required 1 0003", bus.done, bus.out);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("FAIL back_to_back_pulse got done=%b required 0", bus.done);
      end
   endtask

   task automatic test_mul_reset();
      send(3'b000, 16'h8000, 16'h8000);
      @(negedge clk);
      send(3'b100, 16'h1234, 16'h0005);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.out, bus.Z, bus.N, bus.V, bus.busy, bus.done, bus.illegal} !== {W'(0), 6'b0}) begin
         errors++;
         $display("FAIL mul_reset got out=%h ZNV=%b%b%b busy=%b done=%b ill=%b required all 0",
                  bus.out, bus.Z, bus.N, bus.V, bus.busy, bus.done, bus.illegal);
      end
      exp_q.delete();
      cur_exp = '0;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (W) @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out !== '0) begin
         errors++;
         $display("FAIL mul_reset_after got done=%b busy=%b out=%h required 0 0 0000", bus.done, bus.busy, bus.out);
      end
   endtask
`endif

   initial begin
      checks    = 0;
      errors    = 0;
      cur_exp   = '0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.ALUop = 3'b000;
      bus.Ain   = '0;
      bus.Bin   = '0;
      test_reset();
      test_single_ops();
      test_back_to_back_random();
      test_hold_and_illegal();
`ifdef ALU_MUL_EN
      test_mul();
      test_mul_ignore_and_back_to_back();
      test_mul_reset();
`endif
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got %0d pending results required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
